// File: rtl/demux_1_2_stream.sv
// 1:2 valid/ready stream demux with one registered stage per output.
// Optional packet lock (destination held from first to last beat) under `DEMUX_PKT_LOCK_EN.
module demux_1_2_stream #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_sel,
    input  logic         in_last,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out0_data,
    output logic         out0_valid,
    input  logic         out0_ready,
    output logic [W-1:0] out1_data,
    output logic         out1_valid,
    input  logic         out1_ready
);

    logic         dst;
    logic         accept;
    logic         free0;
    logic         free1;
    logic         load0;
    logic         load1;
    logic [W-1:0] data0_q, data0_d;
    logic [W-1:0] data1_q, data1_d;
    logic         valid0_q, valid0_d;
    logic         valid1_q, valid1_d;

`ifdef DEMUX_PKT_LOCK_EN
    // state  | meaning
    // IDLE   | between packets, dst follows in_sel
    // LOCKED | inside a packet, dst held at lock_sel_q
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t state_q, state_d;
    logic   lock_sel_q, lock_sel_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lock_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        case (state_q)
            IDLE: begin
                if (accept && !in_last) begin
                    state_d    = LOCKED;
                    lock_sel_d = in_sel;
                end
            end
            LOCKED: begin
                if (accept && in_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dst = in_sel;
        if (state_q == LOCKED) begin
            dst = lock_sel_q;
        end
    end
`else
    logic unused_last;

    assign unused_last = in_last;
    assign dst         = in_sel;
`endif

    assign free0    = !valid0_q || out0_ready;
    assign free1    = !valid1_q || out1_ready;
    assign in_ready = dst ? free1 : free0;
    assign accept   = in_valid && in_ready;
    assign load0    = accept && !dst;
    assign load1    = accept && dst;

    // A load wins over a drain on the same stage, so back-to-back beats leave no bubble.
    always_comb begin
        valid0_d = valid0_q;
        data0_d  = data0_q;
        if (load0) begin
            valid0_d = 1'b1;
            data0_d  = in_data;
        end else if (out0_ready) begin
            valid0_d = 1'b0;
        end
    end

    always_comb begin
        valid1_d = valid1_q;
        data1_d  = data1_q;
        if (load1) begin
            valid1_d = 1'b1;
            data1_d  = in_data;
        end else if (out1_ready) begin
            valid1_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            data0_q  <= '0;
            data1_q  <= '0;
        end else begin
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
        end
    end

    assign out0_valid = valid0_q;
    assign out0_data  = data0_q;
    assign out1_valid = valid1_q;
    assign out1_data  = data1_q;

endmodule

// File: tb/tb_demux_1_2_stream.sv
// Directed bench for demux_1_2_stream; expectations are hand-computed per vector.
module tb_demux_1_2_stream;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_sel;
    logic         in_last;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out0_data;
    logic         out0_valid;
    logic         out0_ready;
    logic [W-1:0] out1_data;
    logic         out1_valid;
    logic         out1_ready;

    int checks   = 0;
    int failures = 0;

    demux_1_2_stream #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] d, input logic s, input logic l, input logic v);
        in_data  = d;
        in_sel   = s;
        in_last  = l;
        in_valid = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_outs(input string tag, input logic v0, input logic [W-1:0] d0,
                               input logic v1, input logic [W-1:0] d1);
        chk({tag, ".v0"}, 32'(out0_valid), 32'(v0));
        if (v0) chk({tag, ".d0"}, 32'(out0_data), 32'(d0));
        chk({tag, ".v1"}, 32'(out1_valid), 32'(v1));
        if (v1) chk({tag, ".d1"}, 32'(out1_data), 32'(d1));
    endtask

    logic [W-1:0] alt_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic         alt_sel  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic         pkt_exp_sel;

    initial begin
        rst        = 1'b1;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drive(8'hFF, 1'b0, 1'b0, 1'b1);
        #1;

        // reset held two cycles with a valid beat offered
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_outs("rst", 1'b0, 8'h00, 1'b0, 8'h00);
            chk("rst.d0", 32'(out0_data), 32'h0);
            chk("rst.d1", 32'(out1_data), 32'h0);
        end
        rst = 1'b0;
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst.in_ready0", 32'(in_ready), 32'h1);
        in_sel = 1'b1;
        #1;
        chk("rst.in_ready1", 32'(in_ready), 32'h1);

        // alternating select, both sinks ready
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(alt_data[i], alt_sel[i], 1'b1, 1'b1);
            #1;
            chk("alt.in_ready", 32'(in_ready), 32'h1);
            tick();
            if (alt_sel[i]) expect_outs("alt", 1'b0, 8'h00, 1'b1, alt_data[i]);
            else            expect_outs("alt", 1'b1, alt_data[i], 1'b0, 8'h00);
        end
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        expect_outs("alt.idle", 1'b0, 8'h00, 1'b0, 8'h00);

        // backpressure on out1 must not block out0
        out1_ready = 1'b0;
        drive(8'hA1, 1'b1, 1'b1, 1'b1);
        tick();
        expect_outs("bp.a1", 1'b0, 8'h00, 1'b1, 8'hA1);
        drive(8'hB0, 1'b0, 1'b1, 1'b1);
        #1;
        chk("bp.b0_ready", 32'(in_ready), 32'h1);
        tick();
        expect_outs("bp.b0", 1'b1, 8'hB0, 1'b1, 8'hA1);
        drive(8'hA2, 1'b1, 1'b1, 1'b1);
        #1;
        chk("bp.a2_stall", 32'(in_ready), 32'h0);
        tick();
        expect_outs("bp.hold", 1'b0, 8'h00, 1'b1, 8'hA1);
        chk("bp.a2_still", 32'(in_ready), 32'h0);
        out1_ready = 1'b1;
        #1;
        chk("bp.release", 32'(in_ready), 32'h1);
        tick();
        expect_outs("bp.a2", 1'b0, 8'h00, 1'b1, 8'hA2);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        expect_outs("bp.drain", 1'b0, 8'h00, 1'b0, 8'h00);

        // same-cycle load/drain on out0
        for (int i = 0; i < 8; i++) begin
            drive(W'(i), 1'b0, 1'b1, 1'b1);
            tick();
            expect_outs("ld_dr", 1'b1, W'(i), 1'b0, 8'h00);
        end
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        expect_outs("ld_dr.end", 1'b0, 8'h00, 1'b0, 8'h00);

        // reset while out0 stalled
        out0_ready = 1'b0;
        drive(8'h5A, 1'b0, 1'b1, 1'b1);
        tick();
        expect_outs("rs.hold", 1'b1, 8'h5A, 1'b0, 8'h00);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        expect_outs("rs.rst", 1'b0, 8'h00, 1'b0, 8'h00);
        chk("rs.d0", 32'(out0_data), 32'h0);
        rst = 1'b0;
        tick();
        chk("rs.after", 32'(out0_valid), 32'h0);
        out0_ready = 1'b1;
        tick();
        chk("rs.after_rdy", 32'(out0_valid), 32'h0);

        // packet stimulus: C0 sel1, C1 sel0, C2 sel0 last
`ifdef DEMUX_PKT_LOCK_EN
        pkt_exp_sel = 1'b1;
`else
        pkt_exp_sel = 1'b0;
`endif
        drive(8'hC0, 1'b1, 1'b0, 1'b1);
        tick();
        expect_outs("pkt.c0", 1'b0, 8'h00, 1'b1, 8'hC0);
        drive(8'hC1, 1'b0, 1'b0, 1'b1);
        tick();
        if (pkt_exp_sel) expect_outs("pkt.c1", 1'b0, 8'h00, 1'b1, 8'hC1);
        else             expect_outs("pkt.c1", 1'b1, 8'hC1, 1'b0, 8'h00);
        drive(8'hC2, 1'b0, 1'b1, 1'b1);
        tick();
        if (pkt_exp_sel) expect_outs("pkt.c2", 1'b0, 8'h00, 1'b1, 8'hC2);
        else             expect_outs("pkt.c2", 1'b1, 8'hC2, 1'b0, 8'h00);
        drive(8'hD0, 1'b0, 1'b1, 1'b1);
        tick();
        expect_outs("pkt.d0", 1'b1, 8'hD0, 1'b0, 8'h00);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
